sgbm_axi_rd_arb: RTL
====================

Name: sgbm_axi_rd_arb

Overview:
- Round-robin arbiter sharing the single sgbm AXI read master (64-bit data, 4-bit arlen) between image-fetch requesters.
- Requester 0 is the left image fetch; requester 1 is the right image fetch.
- Sits between the fetch units inside sgbm and the m_axi_ar*/m_axi_r* ports that connect to ext_ram_32 in the bench.
- One burst outstanding at a time; read data and rlast are steered back to the owning requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ID_BASE, 6'd0, arid issued = ID_BASE + owner index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_req  in  NUM_REQ  burst request per requester; level, held until o_gnt.
- i_addr  in  NUM_REQ*32  byte address per requester; 8-byte aligned.
- i_len  in  NUM_REQ*4  arlen per requester (beats-1).
- o_gnt  out  NUM_REQ  one-cycle pulse when that requester's AR is accepted.
- o_rdata  out  64  read data, shared by all requesters.
- o_rvalid  out  NUM_REQ  data valid, owner bit only.
- o_rlast  out  NUM_REQ  last beat, owner bit only.
- i_rready  in  NUM_REQ  per-requester ready.
- o_busy  out  1  state != IDLE.
- o_err  out  1  sticky beat-count mismatch.
- m_axi_arvalid/arready/araddr[31:0]/arlen[3:0]/arid[5:0]/arsize[2:0]/arburst[1:0]/arprot[2:0]/arcache[3:0]/arlock[1:0]/arqos[3:0]  AR channel (direction per AXI master).
- m_axi_rvalid/rready/rdata[63:0]/rlast/rrid[5:0]/rresp[1:0]  R channel (direction per AXI master).

Behaviour:
- Reset: state IDLE, rr pointer = NUM_REQ-1 (requester 0 wins first), beat counter = 0, all of the following = 0: m_axi_arvalid, m_axi_rready, o_gnt, o_rvalid, o_rlast, o_err. The slave shares rst, so no stale beats arrive after reset.
- Constant AR fields: arsize=3'b011, arburst=2'b01, arcache=4'b0011, arprot=0, arlock=0, arqos=0.
- IDLE:
  - If any i_req is high, pick the first requester after the rr pointer (wrapping).
  - Register owner, araddr and arlen from that requester; go to ADDR next cycle.
  - Latency from req to arvalid is 1 cycle.
- ADDR:
  - arvalid=1; araddr, arlen and arid stay stable until arready.
  - On arvalid&arready: o_gnt[owner] pulses in the following cycle, beat counter is cleared, state goes to DATA.
  - A requester dropping i_req during ADDR is ignored; the burst is committed.
- DATA:
  - m_axi_rready = i_rready[owner] (combinational).
  - o_rvalid[owner] = m_axi_rvalid and o_rlast[owner] = m_axi_rlast; o_rdata = m_axi_rdata (combinational).
  - Every other requester sees rvalid=0.
  - The beat counter increments on each rvalid&rready.
  - On the handshake with rlast: rr pointer = owner, state goes to IDLE.
  - New arbitration happens in IDLE, giving a 1 idle cycle between bursts.
- Error: set o_err (sticky until rst) if either:
  - rlast arrives when count != arlen, or
  - count reaches arlen+1 without rlast.
  - The FSM still exits on rlast.
- rresp and rrid are not checked by the arbiter.
- Simultaneous requests: round robin gives strict alternation, 0,1,0,1...
- A single active requester is re-granted every burst.
- Bursts must not cross a 4 KB boundary; the requester guarantees this.

Optional Feature:
- Macro: SGBM_RD_ARB_PERF_EN.
- With the macro defined, adds:
  - output o_perf_bursts [NUM_REQ*32], per-requester count of accepted ARs;
  - output o_perf_wait [NUM_REQ*32], cycles each requester had i_req high without being the owner.
  - Both counters saturate at 32'hFFFFFFFF and clear on rst.
- Without the macro: the ports and counters are absent. No other behaviour change.

Decomposition:
- Shared sgbm_defines.v gets:
  - the AXI constants (AXI_SIZE_8B, AXI_BURST_INCR, AXI_CACHE_DEF);
  - the FSM encodings RDARB_IDLE=2'd0, RDARB_ADDR=2'd1, RDARB_DATA=2'd2.
- One sub-module: sgbm_rr_pick (combinational first-set-after-pointer selector, NUM_REQ wide). It is reusable by a future write arbiter.

Test Plan:
- Single request: req0 at addr 32'h20000000, len 15, slave arready after 2 cycles -> araddr=32'h20000000, arlen=15, arid=0; o_gnt[0] pulses once; 16 beats with o_rvalid[0]; o_rlast[0] on beat 16; o_err=0.
- Contention: req0 and req1 held high together, with addresses 32'h20000000 and 32'h21000000 -> AR order 0,1,0,1; arid alternates 0/1; o_rvalid[1] never high during a requester-0 burst.
- Backpressure: i_rready[1] toggled from the random_val pattern -> m_axi_rready mirrors it; 8 beats delivered in order with no loss.
- Error: len 7 with the slave asserting rlast on beat 5 -> o_err=1 and stays 1; FSM returns to IDLE; the next burst completes normally.
- Reset mid-burst: rst for 1 cycle during DATA beat 3 -> next cycle arvalid=0, rready=0, o_busy=0; a subsequent req1 is granted first, with requester 0 having priority order restored.
- With SGBM_RD_ARB_PERF_EN defined: 10 contended bursts -> o_perf_bursts = 5 and 5; o_perf_wait is nonzero for both requesters.

Source files
------------

// File: rtl/sgbm_axi_rd_arb_pkg.sv
// Shared AXI constants, FSM encodings and helper types for the sgbm read arbiter.
package sgbm_axi_rd_arb_pkg;

  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_DEF  = 4'b0011;

  localparam logic [1:0] RDARB_IDLE = 2'd0;
  localparam logic [1:0] RDARB_ADDR = 2'd1;
  localparam logic [1:0] RDARB_DATA = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = RDARB_IDLE,
    ST_ADDR = RDARB_ADDR,
    ST_DATA = RDARB_DATA
  } rdarb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [5:0]  id;
  } ar_cmd_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sgbm_rr_pick.sv
// Combinational round-robin selector: first set request strictly after ptr, wrapping.
module sgbm_rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          vld
);

  always_comb begin
    int best;
    best = N;
    idx  = '0;
    vld  = 1'b0;
    // Distance 0 is the requester right after ptr; ptr itself is distance N-1.
    for (int j = 0; j < N; j++) begin
      if (req[j] && (((j - int'(ptr) - 1 + 2 * N) % N) < best)) begin
        best = (j - int'(ptr) - 1 + 2 * N) % N;
        idx  = PW'(j);
        vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sgbm_axi_rd_arb.sv
// Round-robin arbiter sharing one AXI read master; req->arvalid 1 cycle, one burst outstanding,
// R backpressure passes straight through from the owner. Optional perf counters: SGBM_RD_ARB_PERF_EN.
module sgbm_axi_rd_arb
  import sgbm_axi_rd_arb_pkg::*;
#(
  parameter int         NUM_REQ = 2,
  parameter logic [5:0] ID_BASE = 6'd0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      i_req,
  input  logic [NUM_REQ*32-1:0]   i_addr,
  input  logic [NUM_REQ*4-1:0]    i_len,
  output logic [NUM_REQ-1:0]      o_gnt,
  output logic [63:0]             o_rdata,
  output logic [NUM_REQ-1:0]      o_rvalid,
  output logic [NUM_REQ-1:0]      o_rlast,
  input  logic [NUM_REQ-1:0]      i_rready,
  output logic                    o_busy,
  output logic                    o_err,
`ifdef SGBM_RD_ARB_PERF_EN
  output logic [NUM_REQ*32-1:0]   o_perf_bursts,
  output logic [NUM_REQ*32-1:0]   o_perf_wait,
`endif
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  output logic [31:0]             m_axi_araddr,
  output logic [3:0]              m_axi_arlen,
  output logic [5:0]              m_axi_arid,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arcache,
  output logic [1:0]              m_axi_arlock,
  output logic [3:0]              m_axi_arqos,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic [63:0]             m_axi_rdata,
  input  logic                    m_axi_rlast,
  input  logic [5:0]              m_axi_rrid,
  input  logic [1:0]              m_axi_rresp
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  rdarb_state_t  state;
  logic [PW-1:0] owner;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] pick_idx;
  logic          pick_vld;
  ar_cmd_t       cmd;
  logic [4:0]    beat_cnt;

  sgbm_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req (i_req),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      rr_ptr        <= PW'(NUM_REQ - 1);
      owner         <= '0;
      cmd           <= '0;
      beat_cnt      <= '0;
      m_axi_arvalid <= 1'b0;
      o_gnt         <= '0;
      o_err         <= 1'b0;
    end else begin
      o_gnt <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            owner         <= pick_idx;
            cmd.addr      <= i_addr[32 * int'(pick_idx) +: 32];
            cmd.len       <= i_len[4 * int'(pick_idx) +: 4];
            cmd.id        <= ID_BASE + 6'(pick_idx);
            m_axi_arvalid <= 1'b1;
            state         <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          // Burst is committed once registered; a dropped i_req is not looked at here.
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            o_gnt[owner]  <= 1'b1;
            beat_cnt      <= '0;
            state         <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (m_axi_rvalid && m_axi_rready) begin
            beat_cnt <= beat_cnt + 5'd1;
            if (m_axi_rlast) begin
              if (beat_cnt != {1'b0, cmd.len}) o_err <= 1'b1;
              rr_ptr <= owner;
              state  <= ST_IDLE;
            end else if (beat_cnt == {1'b0, cmd.len}) begin
              // Final expected beat went by without rlast: slave overran arlen.
              o_err <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_rvalid     = '0;
    o_rlast      = '0;
    m_axi_rready = 1'b0;
    if (state == ST_DATA) begin
      m_axi_rready    = i_rready[owner];
      o_rvalid[owner] = m_axi_rvalid;
      o_rlast[owner]  = m_axi_rlast;
    end
  end

  assign o_rdata       = m_axi_rdata;
  assign o_busy        = (state != ST_IDLE);
  assign m_axi_araddr  = cmd.addr;
  assign m_axi_arlen   = cmd.len;
  assign m_axi_arid    = cmd.id;
  assign m_axi_arsize  = AXI_SIZE_8B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arcache = AXI_CACHE_DEF;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arlock  = 2'b00;
  assign m_axi_arqos   = 4'b0000;

  logic unused;
  assign unused = ^{m_axi_rrid, m_axi_rresp};

`ifdef SGBM_RD_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_perf_bursts <= '0;
      o_perf_wait   <= '0;
    end else begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (state == ST_ADDR && m_axi_arready && owner == PW'(r))
          o_perf_bursts[r*32 +: 32] <= sat_inc32(o_perf_bursts[r*32 +: 32]);
        if (i_req[r] && !(state != ST_IDLE && owner == PW'(r)))
          o_perf_wait[r*32 +: 32] <= sat_inc32(o_perf_wait[r*32 +: 32]);
      end
    end
  end
`endif

endmodule
